// File: rtl/nios_uart_debug_monitor_pkg.sv
// Shared types and jdo field positions for the debug monitor memory.
// The read-after-set flag and the write data MSB are deliberately the same bit.
package nios_uart_debug_monitor_pkg;
  typedef enum logic [2:0] {
    IDLE,
    JRD,
    JCAP,
    JWR,
    CRD
  } mon_state_t;

  localparam int ADDR_LSB   = 17;
  localparam int RDFLAG_BIT = 34;
  localparam int DATA_MSB   = 34;
  localparam int DATA_LSB   = 3;
endpackage

// File: rtl/nios_uart_debug_monitor_ram.sv
// Single-port 32-bit synchronous RAM with a registered read port.
// The contents are not reset, so block RAM can be inferred.
module nios_uart_debug_monitor_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] q_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q_reg <= mem[addr];
  end

  assign q = q_reg;
endmodule

// File: rtl/nios_uart_debug_monitor_mem.sv
// Debug monitor RAM shared between the JTAG debug slave (priority) and an
// Avalon-MM CPU slave; decodes the ocimem strobes into reads and writes.
module nios_uart_debug_monitor_mem
  import nios_uart_debug_monitor_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  mon_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] mon_a_reg, mon_a_next;
  logic [31:0]       mon_d_reg, mon_d_next;
  logic [31:0]       wr_data_reg, wr_data_next;
  logic              err_reg, err_next;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;
  logic              any_strobe;
  logic              cpu_req;
  logic              unused_jdo_bits;

  assign any_strobe      = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign cpu_req         = avs_read | avs_write;
  assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_a_reg   <= '0;
      mon_d_reg   <= '0;
      wr_data_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      mon_a_reg   <= mon_a_next;
      mon_d_reg   <= mon_d_next;
      wr_data_reg <= wr_data_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    mon_a_next      = mon_a_reg;
    mon_d_next      = mon_d_reg;
    wr_data_next    = wr_data_reg;
    err_next        = err_reg;
    ram_we          = 1'b0;
    ram_addr        = avs_address;
    ram_wdata       = avs_writedata;
    avs_waitrequest = 1'b0;

    case (state_reg)
      IDLE: begin
        // JTAG wins over the CPU; an accepted set-address clears the error
        // even when a lower-priority strobe is dropped alongside it.
        if (take_action_ocimem_b) begin
          state_next   = JWR;
          wr_data_next = jdo[DATA_MSB:DATA_LSB];
          if (take_action_ocimem_a || take_no_action_ocimem_a) begin
            err_next = 1'b1;
          end
        end else if (take_action_ocimem_a) begin
          mon_a_next = jdo[ADDR_LSB +: ADDR_W];
          err_next   = 1'b0;
          if (jdo[RDFLAG_BIT]) begin
            state_next = JRD;
          end
        end else if (take_no_action_ocimem_a) begin
          state_next = JRD;
        end else if (avs_read) begin
          state_next = CRD;
        end else if (avs_write) begin
          ram_we = 1'b1;
        end
        avs_waitrequest = any_strobe | avs_read;
      end
      JRD: begin
        ram_addr        = mon_a_reg;
        state_next      = JCAP;
        avs_waitrequest = cpu_req;
      end
      JCAP: begin
        mon_d_next      = ram_q;
        mon_a_next      = mon_a_reg + ADDR_W'(1);
        state_next      = IDLE;
        avs_waitrequest = cpu_req;
      end
      JWR: begin
        ram_we          = 1'b1;
        ram_addr        = mon_a_reg;
        ram_wdata       = wr_data_reg;
        mon_d_next      = wr_data_reg;
        mon_a_next      = mon_a_reg + ADDR_W'(1);
        state_next      = IDLE;
        avs_waitrequest = cpu_req;
      end
      CRD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (state_reg != IDLE && any_strobe) begin
      err_next = 1'b1;
    end
    // Hold off the CPU and block RAM writes while reset is asserted.
    if (!reset_n) begin
      ram_we          = 1'b0;
      avs_waitrequest = cpu_req;
    end
  end

  nios_uart_debug_monitor_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .q    (ram_q)
  );

  assign avs_readdata  = (state_reg == CRD) ? ram_q : 32'd0;
  assign MonDReg       = mon_d_reg;
  assign monitor_ready = (state_reg == IDLE);
  assign monitor_error = err_reg;
endmodule
